mem_req_controller: RTL
=======================

# mem_req_controller

Request front-end that sits directly upstream of the cache/memory hierarchy. Accepts word read/write requests from the processor over a valid/ready handshake, buffers them in a small FIFO, and drives the hierarchy's read_en/write_en/address/write_data. Holds each access stable until the hierarchy reports hit, then returns one response per request over a valid/ready channel. Flags misaligned accesses and hung accesses (timeout) as errors.

## Interface
- QDEPTH, 4: request FIFO depth; power of two, at least 2.
- TIMEOUT, 64: maximum ACCESS cycles before an error response; at least 8.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  16  byte address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  misaligned or timed out.
- mh_read_en  out  1  to hierarchy read_en.
- mh_write_en  out  1  to hierarchy write_en.
- mh_address  out  16  to hierarchy address.
- mh_write_data  out  32  to hierarchy write_data.
- mh_read_data  in  32  from hierarchy read_data.
- mh_hit  in  1  from hierarchy hit.
- stat_hits  out  16  first-cycle hits (see Configuration).
- stat_misses  out  16  accesses that needed a refill.
- stat_timeouts  out  16  timed-out accesses.

## Operation
- FIFO push on req_valid && req_ready. req_ready = (count != QDEPTH), computed from the registered count.
- A push and a pop in the same cycle leave count unchanged. A push while full is impossible by the handshake.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if the FIFO is non-empty, pop into the hold register (we, addr, wdata) and clear the cycle counter.
  - If addr[1:0] != 0, go to RESP with rsp_err=1.
  - Otherwise go to ACCESS.
- ACCESS: mh_read_en = !we and mh_write_en = we. Address and data stay constant from the hold register. The counter increments every cycle.
  - On mh_hit=1 at the edge: capture mh_read_data (reads only; writes capture 0), set err=0, go to RESP.
  - Else, when the counter reaches TIMEOUT-1: set err=1, rdata=0, go to RESP.
  - A hit in the same cycle as the timeout is treated as a hit.
- RESP: rsp_valid=1 with stable rsp_rdata and rsp_err. On rsp_ready, go to IDLE.
- Enables are 0 in every state except ACCESS. mh_address and mh_write_data reflect the hold register at all times.
- One access is outstanding at a time. Responses return in request order.

## Timing
- Reset values: state IDLE, FIFO empty, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mh_* = 0, stats = 0.
- Reset mid-operation drops queued and in-flight requests. Hierarchy enables fall to 0 immediately.
- Latency for a hit: request accepted at edge k, popped at k+1, ACCESS during cycle k+1, mh_hit sampled at k+2, rsp_valid high from k+2. This is 2 cycles for a hit.
- Misaligned request: rsp_valid high from k+2 with err=1, and no enable is ever asserted.
- Miss: enables stay continuously asserted through the hierarchy's writeback/refill. The response comes 1 cycle after the first mh_hit=1.
- rsp_valid holds until rsp_ready. During this time no new access is issued, while the FIFO continues to accept requests.

## Configuration
- MEM_REQ_STATS_EN defined: 16-bit saturating counters.
  - stat_hits increments when an access ends with a hit on its first ACCESS cycle.
  - stat_misses increments when an access ends with a hit on any later cycle.
  - stat_timeouts increments on each timeout.
  - Misaligned requests count in none of them.
- MEM_REQ_STATS_EN undefined: counters are not built and all stat_* outputs are tied to 0.

## Structure
- Package mem_req_pkg holds:
  - the state_t enum (IDLE, ACCESS, RESP);
  - the req_t struct (we, addr[15:0], wdata[31:0]);
  - ADDR_W=16 and DATA_W=32;
  - the default values of QDEPTH and TIMEOUT.
- One sub-module, req_fifo: a synchronous FIFO of req_t with push, pop, full, empty and count, and asynchronous reset.

## Test plan
- Read 0x0040 with mh_hit tied 1 and mh_read_data=0xDEADBEEF -> rsp_valid at accept+2, rsp_rdata=0xDEADBEEF, err=0, stat_hits=1.
- Write 0x0080 with data 0x12345678, mh_hit low for 4 ACCESS cycles then high -> mh_write_en high for 5 cycles with the address stable, response err=0 and rdata=0, stat_misses=1.
- Read 0x0043 -> err=1 response at accept+2, and mh_read_en/mh_write_en never asserted.
- mh_hit held 0 with TIMEOUT=8 -> enables high for exactly 8 cycles, then err=1 and stat_timeouts=1.
- Push 5 requests back-to-back with rsp_ready=0 and QDEPTH=4 -> req_ready drops after the FIFO fills. Release rsp_ready -> 5 in-order responses.
- Assert reset during an ACCESS miss -> enables 0 immediately, FIFO empty, req_ready=1, rsp_valid=0.

Source files
------------

// File: rtl/mem_req_pkg.sv
// Shared types and defaults for the memory request front-end.
package mem_req_pkg;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 32;
  localparam int QDEPTH_DEF  = 4;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/req_fifo.sv
// Request FIFO: synchronous push/pop of req_t, asynchronous active-high reset.
// DEPTH must be a power of two so the pointers wrap on their own.
module req_fifo
  import mem_req_pkg::*;
#(
  parameter int DEPTH = QDEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  req_t                     wdata,
  output req_t                     rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  req_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     cnt_q;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata;
  end

  // Pointers and occupancy; push+pop together leaves the count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_q];
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/mem_req_controller.sv
// Memory request front-end: queues processor requests, drives the cache/memory
// hierarchy one access at a time, returns in-order responses with error flags.
// Optional hit/miss/timeout statistics are built when MEM_REQ_STATS_EN is defined.
module mem_req_controller
  import mem_req_pkg::*;
#(
  parameter int QDEPTH  = QDEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mh_read_en,
  output logic              mh_write_en,
  output logic [ADDR_W-1:0] mh_address,
  output logic [DATA_W-1:0] mh_write_data,
  input  logic [DATA_W-1:0] mh_read_data,
  input  logic              mh_hit,
  output logic [15:0]       stat_hits,
  output logic [15:0]       stat_misses,
  output logic [15:0]       stat_timeouts
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t              state_q, state_d;
  req_t                hold_q, hold_d;
  logic                mis_q, mis_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  req_t                fifo_in, fifo_out;
  logic                push, pop, full, empty;
  logic [$clog2(QDEPTH):0] fifo_cnt;
  logic                ev_hit1, ev_miss, ev_tmo;

  assign fifo_in = '{we: req_we, addr: req_addr, wdata: req_wdata};
  assign push    = req_valid && req_ready;

  req_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (fifo_in),
    .rdata (fifo_out),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );

  // State, hold register, cycle counter and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state and access sequencing. A misaligned request spends its first
  // post-pop cycle in ACCESS with the enables suppressed, so its error
  // response lands at the same latency as a first-cycle hit.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    pop     = 1'b0;
    ev_hit1 = 1'b0;
    ev_miss = 1'b0;
    ev_tmo  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          hold_d  = fifo_out;
          mis_d   = (fifo_out.addr[1:0] != 2'b00);
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (mis_q) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (mh_hit) begin
          rdata_d = hold_q.we ? '0 : mh_read_data;
          err_d   = 1'b0;
          state_d = RESP;
          ev_hit1 = (cnt_q == '0);
          ev_miss = (cnt_q != '0);
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
          ev_tmo  = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready     = !full;
  assign rsp_valid     = (state_q == RESP);
  assign rsp_rdata     = rdata_q;
  assign rsp_err       = err_q;
  assign mh_read_en    = (state_q == ACCESS) && !mis_q && !hold_q.we;
  assign mh_write_en   = (state_q == ACCESS) && !mis_q &&  hold_q.we;
  assign mh_address    = hold_q.addr;
  assign mh_write_data = hold_q.wdata;

  logic unused_cnt;
  assign unused_cnt = ^fifo_cnt;

`ifdef MEM_REQ_STATS_EN
  logic [15:0] hits_q, misses_q, tmos_q;

  // Saturating access statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hits_q   <= '0;
      misses_q <= '0;
      tmos_q   <= '0;
    end else begin
      if (ev_hit1 && hits_q   != 16'hFFFF) hits_q   <= hits_q   + 1'b1;
      if (ev_miss && misses_q != 16'hFFFF) misses_q <= misses_q + 1'b1;
      if (ev_tmo  && tmos_q   != 16'hFFFF) tmos_q   <= tmos_q   + 1'b1;
    end
  end

  assign stat_hits     = hits_q;
  assign stat_misses   = misses_q;
  assign stat_timeouts = tmos_q;
`else
  logic unused_ev;
  assign unused_ev     = ev_hit1 ^ ev_miss ^ ev_tmo;
  assign stat_hits     = '0;
  assign stat_misses   = '0;
  assign stat_timeouts = '0;
`endif

endmodule
